// File: rtl/acc_job_scheduler_pkg.sv
// Shared types and constants for the accelerator job scheduler.
package acc_job_scheduler_pkg;

    typedef enum logic [2:0] {
        IDLE       = 3'd0,
        DRIVE      = 3'd1,
        RELEASE    = 3'd2,
        WAIT_START = 3'd3,
        WAIT_BUSY  = 3'd4,
        WAIT_DONE  = 3'd5
    } state_t;

    localparam int LAST_BYTE = 2;
    localparam int JOB_W     = 24;

endpackage

// File: rtl/acc_job_scheduler_if.sv
// Requester and input-wrapper signals of the scheduler; master is the scheduler side.
interface acc_job_scheduler_if #(
    parameter int N_REQ = 2,
    parameter int IDW   = 2
);
    import acc_job_scheduler_pkg::*;

    logic [N_REQ-1:0]    req;
    logic [16*N_REQ-1:0] job_x;
    logic [8*N_REQ-1:0]  job_y;
    logic [N_REQ-1:0]    gnt;
    logic [N_REQ-1:0]    done;
    logic [IDW-1:0]      owner;
    logic                busy;
    logic [7:0]          bus;
    logic                drdy;
    logic                dac;
    logic                acc_start;
    logic                acc_ready;
    logic [15:0]         job_count;

    modport master (
        input  req, job_x, job_y, dac, acc_start, acc_ready,
        output gnt, done, owner, busy, bus, drdy, job_count
    );

    modport slave (
        output req, job_x, job_y, dac, acc_start, acc_ready,
        input  gnt, done, owner, busy, bus, drdy, job_count
    );

endinterface

// File: rtl/acc_job_scheduler_rr.sv
// Combinational round-robin pick: first request found searching from i_last+1 with wrap.
module rr_arbiter_n #(
    parameter int N_REQ = 2,
    parameter int IDW   = 2
) (
    input  logic [N_REQ-1:0] i_req,
    input  logic [IDW-1:0]   i_last,
    output logic [N_REQ-1:0] o_gnt,
    output logic [IDW-1:0]   o_idx,
    output logic             o_any
);

    // Walk distances from farthest to nearest so the nearest requester overwrites.
    always_comb begin
        o_gnt = '0;
        o_idx = '0;
        o_any = 1'b0;
        for (int k = N_REQ; k >= 1; k--) begin
            for (int c = 0; c < N_REQ; c++) begin
                if (i_req[c] && (c == ((int'(i_last) + k) % N_REQ))) begin
                    o_gnt    = '0;
                    o_gnt[c] = 1'b1;
                    o_idx    = c[IDW-1:0];
                    o_any    = 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/acc_job_scheduler.sv
// Arbitrates N_REQ requesters, streams the winning job as three bytes over drdy/dac,
// then follows the accelerator start/ready sequence and pulses done to the owner.
module acc_job_scheduler
    import acc_job_scheduler_pkg::*;
#(
    parameter int N_REQ = 2,
    parameter int IDW   = 2
) (
    input  logic                clk,
    input  logic                rst,
    acc_job_scheduler_if.master sif
);

    state_t             r_state,     w_state_nxt;
    logic [IDW-1:0]     r_last,      w_last_nxt;
    logic [IDW-1:0]     r_owner,     w_owner_nxt;
    logic [N_REQ-1:0]   r_gnt,       w_gnt_nxt;
    logic [N_REQ-1:0]   r_done,      w_done_nxt;
    logic               r_busy,      w_busy_nxt;
    logic               r_drdy,      w_drdy_nxt;
    logic [7:0]         r_bus,       w_bus_nxt;
    logic [JOB_W-1:0]   r_shift,     w_shift_nxt;
    logic [1:0]         r_byte_idx,  w_byte_idx_nxt;
    logic [15:0]        r_job_count, w_job_count_nxt;

    logic [N_REQ-1:0]   w_arb_gnt;
    logic [IDW-1:0]     w_arb_idx;
    logic               w_arb_any;
    logic [JOB_W-1:0]   w_job;

    rr_arbiter_n #(.N_REQ(N_REQ), .IDW(IDW)) u_arb (
        .i_req  (sif.req),
        .i_last (r_last),
        .o_gnt  (w_arb_gnt),
        .o_idx  (w_arb_idx),
        .o_any  (w_arb_any)
    );

    // Job word laid out so the shift register emits x_lo, x_hi, y in order.
    always_comb begin
        w_job = '0;
        for (int c = 0; c < N_REQ; c++) begin
            if (w_arb_gnt[c]) begin
                w_job = {sif.job_y[8*c +: 8], sif.job_x[16*c +: 16]};
            end
        end
    end

    always_comb begin
        w_state_nxt     = r_state;
        w_last_nxt      = r_last;
        w_owner_nxt     = r_owner;
        w_gnt_nxt       = '0;
        w_done_nxt      = '0;
        w_busy_nxt      = r_busy;
        w_drdy_nxt      = r_drdy;
        w_bus_nxt       = r_bus;
        w_shift_nxt     = r_shift;
        w_byte_idx_nxt  = r_byte_idx;
        w_job_count_nxt = r_job_count;
        case (r_state)
            IDLE: begin
                if (w_arb_any) begin
                    w_shift_nxt    = w_job;
                    w_bus_nxt      = w_job[7:0];
                    w_drdy_nxt     = 1'b1;
                    w_owner_nxt    = w_arb_idx;
                    w_last_nxt     = w_arb_idx;
                    w_gnt_nxt      = w_arb_gnt;
                    w_busy_nxt     = 1'b1;
                    w_byte_idx_nxt = '0;
                    w_state_nxt    = DRIVE;
                end
            end
            DRIVE: begin
                if (sif.dac) begin
                    w_drdy_nxt  = 1'b0;
                    w_state_nxt = RELEASE;
                end
            end
            RELEASE: begin
                if (!sif.dac) begin
                    if (r_byte_idx == 2'(LAST_BYTE)) begin
                        w_state_nxt = WAIT_START;
                    end else begin
                        w_shift_nxt    = r_shift >> 8;
                        w_bus_nxt      = r_shift[15:8];
                        w_byte_idx_nxt = r_byte_idx + 2'd1;
                        w_drdy_nxt     = 1'b1;
                        w_state_nxt    = DRIVE;
                    end
                end
            end
            WAIT_START: begin
                if (sif.acc_start) w_state_nxt = WAIT_BUSY;
            end
            WAIT_BUSY: begin
                if (!sif.acc_start) w_state_nxt = WAIT_DONE;
            end
            WAIT_DONE: begin
                if (sif.acc_ready) begin
                    for (int c = 0; c < N_REQ; c++) begin
                        if (r_owner == c[IDW-1:0]) w_done_nxt[c] = 1'b1;
                    end
                    w_busy_nxt = 1'b0;
                    if (r_job_count != 16'hFFFF) w_job_count_nxt = r_job_count + 16'd1;
                    w_state_nxt = IDLE;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= IDLE;
            r_last      <= IDW'(N_REQ - 1);
            r_owner     <= '0;
            r_gnt       <= '0;
            r_done      <= '0;
            r_busy      <= 1'b0;
            r_drdy      <= 1'b0;
            r_bus       <= '0;
            r_shift     <= '0;
            r_byte_idx  <= '0;
            r_job_count <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_last      <= w_last_nxt;
            r_owner     <= w_owner_nxt;
            r_gnt       <= w_gnt_nxt;
            r_done      <= w_done_nxt;
            r_busy      <= w_busy_nxt;
            r_drdy      <= w_drdy_nxt;
            r_bus       <= w_bus_nxt;
            r_shift     <= w_shift_nxt;
            r_byte_idx  <= w_byte_idx_nxt;
            r_job_count <= w_job_count_nxt;
        end
    end

    assign sif.gnt       = r_gnt;
    assign sif.done      = r_done;
    assign sif.owner     = r_owner;
    assign sif.busy      = r_busy;
    assign sif.drdy      = r_drdy;
    assign sif.bus       = r_bus;
    assign sif.job_count = r_job_count;

endmodule

// File: tb/tb_acc_job_scheduler.sv
// Scoreboard bench: wrapper/accelerator model plus grant, byte and done checking.
module tb_acc_job_scheduler;

    localparam int N_REQ = 2;
    localparam int IDW   = 2;

    logic clk;
    logic rst;

    acc_job_scheduler_if #(.N_REQ(N_REQ), .IDW(IDW)) sif ();

    acc_job_scheduler #(.N_REQ(N_REQ), .IDW(IDW)) dut (
        .clk (clk),
        .rst (rst),
        .sif (sif)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Bench model state
    logic [N_REQ-1:0] req_s;
    logic [15:0]      x_s [N_REQ];
    logic [7:0]       y_s [N_REQ];
    logic [7:0]       byte_q [$];
    int               done_q [$];
    int               gnt_log [$];
    int               m_last  = N_REQ - 1;
    logic [15:0]      m_count = 16'h0;
    logic [7:0]       m_hold  = 8'h0;
    int               dac_delay = 1;
    int               m_wait  = 0;
    int               m_bytes = 0;
    int               m_acc   = 0;
    int               n_gnt   = 0;
    int               n_done  = 0;

    // Inputs as the DUT sees them at the arbitration edge.
    initial begin
        req_s = '0;
        for (int i = 0; i < N_REQ; i++) begin
            x_s[i] = '0;
            y_s[i] = '0;
        end
        forever begin
            @(posedge clk);
            req_s = sif.req;
            for (int i = 0; i < N_REQ; i++) begin
                x_s[i] = sif.job_x[16*i +: 16];
                y_s[i] = sif.job_y[8*i +: 8];
            end
        end
    end

    task automatic clear_model();
        sif.dac       = 1'b0;
        sif.acc_start = 1'b0;
        sif.acc_ready = 1'b1;
        m_wait  = 0;
        m_bytes = 0;
        m_acc   = 0;
        m_last  = N_REQ - 1;
        m_count = 16'h0;
        byte_q.delete();
        done_q.delete();
    endtask

    initial begin
        sif.dac       = 1'b0;
        sif.acc_start = 1'b0;
        sif.acc_ready = 1'b1;
        forever begin
            @(negedge clk);
            if (rst) begin
                clear_model();
            end else begin
                if (sif.gnt != '0) begin
                    int w;
                    w = -1;
                    for (int k = 1; k <= N_REQ; k++) begin
                        if (w < 0 && req_s[(m_last + k) % N_REQ]) w = (m_last + k) % N_REQ;
                    end
                    if (w < 0) begin
                        check_eq("gnt_spurious", 32'(sif.gnt), 32'h0);
                    end else begin
                        check_eq("gnt", 32'(sif.gnt), 32'(1 << w));
                        check_eq("owner", 32'(sif.owner), 32'(w));
                        check_eq("busy_at_gnt", 32'(sif.busy), 32'h1);
                        check_eq("drdy_at_gnt", 32'(sif.drdy), 32'h1);
                        check_eq("busy_overlap", 32'(done_q.size()), 32'h0);
                        byte_q.push_back(x_s[w][7:0]);
                        byte_q.push_back(x_s[w][15:8]);
                        byte_q.push_back(y_s[w]);
                        done_q.push_back(w);
                        m_last = w;
                    end
                    gnt_log.push_back(int'(sif.owner));
                    n_gnt++;
                end
                if (sif.done != '0) begin
                    if (done_q.size() == 0) begin
                        check_eq("done_spurious", 32'(sif.done), 32'h0);
                    end else begin
                        int w;
                        w = done_q.pop_front();
                        if (m_count != 16'hFFFF) m_count = m_count + 16'd1;
                        check_eq("done", 32'(sif.done), 32'(1 << w));
                        check_eq("busy_at_done", 32'(sif.busy), 32'h0);
                        check_eq("job_count", 32'(sif.job_count), 32'(m_count));
                        check_eq("bytes_left", 32'(byte_q.size()), 32'h0);
                    end
                    n_done++;
                end
                if (sif.drdy && !sif.dac) begin
                    if (m_wait == 0) begin
                        if (byte_q.size() == 0) begin
                            check_eq("byte_extra", 32'(sif.drdy), 32'h0);
                        end else begin
                            m_hold = byte_q.pop_front();
                            check_eq("bus_byte", 32'(sif.bus), 32'(m_hold));
                        end
                    end else begin
                        check_eq("bus_hold", 32'(sif.bus), 32'(m_hold));
                    end
                    m_wait++;
                    if (m_wait >= dac_delay) sif.dac = 1'b1;
                end else if (sif.dac && !sif.drdy) begin
                    sif.dac = 1'b0;
                    m_wait  = 0;
                    m_bytes++;
                    if (m_bytes == 3) begin
                        m_bytes = 0;
                        m_acc   = 1;
                    end
                end else if (!sif.drdy && m_wait > 0) begin
                    check_eq("drdy_hold", 32'(sif.drdy), 32'h1);
                end
                if (m_acc > 0) begin
                    if (m_acc <= 2) begin
                        sif.acc_start = 1'b1;
                        sif.acc_ready = 1'b0;
                    end else begin
                        sif.acc_start = 1'b0;
                    end
                    if (m_acc == 8) begin
                        sif.acc_ready = 1'b1;
                        m_acc = 0;
                    end else begin
                        m_acc++;
                    end
                end
            end
        end
    end

    task automatic reset_dut();
        @(negedge clk);
        rst = 1'b1;
        clear_model();
        @(negedge clk);
        clear_model();
        rst = 1'b0;
    endtask

    task automatic set_job(input int i, input logic [15:0] x, input logic [7:0] y);
        sif.job_x[16*i +: 16] = x;
        sif.job_y[8*i +: 8]   = y;
    endtask

    task automatic wait_gnt(input int target, input string tag);
        int t;
        t = 0;
        while (n_gnt < target && t < 500) begin
            @(negedge clk);
            t++;
        end
        check_eq(tag, 32'(n_gnt), 32'(target));
    endtask

    task automatic wait_done(input int target, input string tag);
        int t;
        t = 0;
        while (n_done < target && t < 2000) begin
            @(negedge clk);
            t++;
        end
        check_eq(tag, 32'(n_done), 32'(target));
    endtask

    task automatic run_job(input int i, input string tag);
        int g;
        int d;
        g = n_gnt;
        d = n_done;
        sif.req = N_REQ'(1 << i);
        wait_gnt(g + 1, {tag, "_gnt_wait"});
        sif.req = '0;
        wait_done(d + 1, {tag, "_done_wait"});
        repeat (2) @(negedge clk);
    endtask

    initial begin
        int g;
        int d;
        int t;
        int exp_order [4];
        rst       = 1'b1;
        sif.req   = '0;
        sif.job_x = '0;
        sif.job_y = '0;
        exp_order = '{0, 1, 0, 1};

        reset_dut();
        check_eq("rst_gnt",   32'(sif.gnt),       32'h0);
        check_eq("rst_done",  32'(sif.done),      32'h0);
        check_eq("rst_owner", 32'(sif.owner),     32'h0);
        check_eq("rst_busy",  32'(sif.busy),      32'h0);
        check_eq("rst_bus",   32'(sif.bus),       32'h0);
        check_eq("rst_drdy",  32'(sif.drdy),      32'h0);
        check_eq("rst_count", 32'(sif.job_count), 32'h0);

        // Single job, bytes 5A A5 3C
        set_job(0, 16'hA55A, 8'h3C);
        run_job(0, "t1");
        check_eq("t1_count", 32'(sif.job_count), 32'h1);

        // Both requesters held: alternation 0,1,0,1 from reset
        reset_dut();
        set_job(0, 16'h1234, 8'h56);
        set_job(1, 16'hBEEF, 8'h77);
        gnt_log.delete();
        d = n_done;
        sif.req = 2'b11;
        wait_gnt(n_gnt + 4, "t2_gnt_wait");
        sif.req = '0;
        wait_done(d + 4, "t2_done_wait");
        for (int i = 0; i < 4; i++) begin
            if (i < gnt_log.size()) check_eq("t2_order", 32'(gnt_log[i]), 32'(exp_order[i]));
        end
        check_eq("t2_log_len", 32'(gnt_log.size()), 32'h4);
        repeat (2) @(negedge clk);

        // Slow wrapper: bus and drdy must hold across the long dac wait
        dac_delay = 7;
        set_job(1, 16'hC0DE, 8'h99);
        run_job(1, "t3");
        dac_delay = 1;

        // Reset during byte 1 aborts without done
        set_job(0, 16'h1111, 8'h22);
        g = n_gnt;
        sif.req = 2'b01;
        wait_gnt(g + 1, "t4_gnt_wait");
        sif.req = '0;
        t = 0;
        while (!(m_bytes == 1 && sif.drdy) && t < 100) begin
            @(negedge clk);
            t++;
        end
        check_eq("t4_byte1_seen", 32'(sif.drdy), 32'h1);
        d = n_done;
        reset_dut();
        check_eq("t4_drdy",  32'(sif.drdy),  32'h0);
        check_eq("t4_busy",  32'(sif.busy),  32'h0);
        check_eq("t4_owner", 32'(sif.owner), 32'h0);
        check_eq("t4_count", 32'(sif.job_count), 32'h0);
        repeat (20) @(negedge clk);
        check_eq("t4_no_done", 32'(n_done), 32'(d));
        set_job(1, 16'h7E57, 8'h5A);
        gnt_log.delete();
        run_job(1, "t4b");
        if (gnt_log.size() > 0) check_eq("t4_winner", 32'(gnt_log[0]), 32'h1);

        // Short req pulse while busy is never granted
        set_job(0, 16'h0F0F, 8'hF0);
        g = n_gnt;
        d = n_done;
        sif.req = 2'b01;
        wait_gnt(g + 1, "t5_gnt_wait");
        sif.req = '0;
        repeat (3) @(negedge clk);
        sif.req = 2'b10;
        @(negedge clk);
        sif.req = '0;
        wait_done(d + 1, "t5_done_wait");
        repeat (15) @(negedge clk);
        check_eq("t5_no_gnt", 32'(n_gnt), 32'(g + 1));
        check_eq("t5_idle_busy", 32'(sif.busy), 32'h0);
        check_eq("t5_idle_drdy", 32'(sif.drdy), 32'h0);

        // Counter saturation: preload near full, then two more jobs
        @(negedge clk);
        force dut.r_job_count = 16'hFFFE;
        @(negedge clk);
        release dut.r_job_count;
        m_count = 16'hFFFE;
        set_job(1, 16'hFACE, 8'hB0);
        run_job(1, "t6a");
        check_eq("t6_full", 32'(sif.job_count), 32'hFFFF);
        run_job(0, "t6b");
        check_eq("t6_sat", 32'(sif.job_count), 32'hFFFF);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
